// File: rtl/sm_shift_right_seq.sv
// Sequential sign-magnitude right shifter that shifts one magnitude bit per clock and uses a start/done handshake.
// Define SM_SHIFT_ROUND_EN to round half away from zero on shifted results; otherwise the result is truncated.
module sm_shift_right_seq #(
    parameter int unsigned N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_out,
    output logic         o_ERR,
    output logic         o_lost
);

    localparam logic [N-2:0] LP_MAX_SHIFT = (N-1)'(N - 1);
    localparam logic [N-2:0] LP_ONE       = (N-1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t       r_state;
    logic         r_sign;
    logic [N-2:0] r_mag;
    logic [N-2:0] r_cnt;
    logic         r_lost;

    logic         w_neg;
    logic [N-2:0] w_amt;
    logic [N-2:0] w_mag_shr;
    logic [N-2:0] w_mag_final;
    logic         w_guard;
    logic         w_lost_next;

    assign w_neg       = i_b[N-1];
    assign w_amt       = i_b[N-2:0];
    assign w_mag_shr   = r_mag >> 1;
    assign w_guard     = r_mag[0];
    assign w_lost_next = r_lost | r_mag[0];

    // The guard bit is the bit dropped by the final shift. The rounding step is applied
    // on the same edge as that shift, so no separate guard register is kept.
`ifdef SM_SHIFT_ROUND_EN
    assign w_mag_final = w_mag_shr + {{(N-2){1'b0}}, w_guard};
`else
    assign w_mag_final = w_mag_shr;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_sign  <= 1'b0;
            r_mag   <= '0;
            r_cnt   <= '0;
            r_lost  <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_out   <= '0;
            o_ERR   <= 1'b0;
            o_lost  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_sign <= i_a[N-1];
                        r_mag  <= i_a[N-2:0];
                        r_cnt  <= w_amt;
                        r_lost <= 1'b0;
                        o_busy <= 1'b1;
                        if (w_neg) begin
                            o_out   <= '0;
                            o_ERR   <= 1'b1;
                            o_lost  <= 1'b0;
                            o_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_amt == '0) begin
                            o_out   <= i_a;
                            o_ERR   <= 1'b0;
                            o_lost  <= 1'b0;
                            o_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_amt > LP_MAX_SHIFT) begin
                            // Every magnitude bit would be shifted out, so the result is computed directly.
                            r_mag   <= '0;
                            o_out   <= {i_a[N-1], {(N-1){1'b0}}};
                            o_ERR   <= 1'b0;
                            o_lost  <= |i_a[N-2:0];
                            o_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_mag  <= w_mag_shr;
                    r_lost <= w_lost_next;
                    r_cnt  <= r_cnt - LP_ONE;
                    if (r_cnt == LP_ONE) begin
                        r_mag   <= w_mag_final;
                        o_out   <= {r_sign, w_mag_final};
                        o_ERR   <= 1'b0;
                        o_lost  <= w_lost_next;
                        o_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_shift_right_seq.sv
// Directed-vector bench for sm_shift_right_seq that checks latency, result, ERR and lost flags, busy-time starts and mid-operation reset.
// Expected values for rounded results depend on SM_SHIFT_ROUND_EN.
module tb_sm_shift_right_seq;

    localparam int unsigned N = 8;

    logic         i_clk;
    logic         i_rst;
    logic         i_start;
    logic [N-1:0] i_a;
    logic [N-1:0] i_b;
    logic         o_busy;
    logic         o_done;
    logic [N-1:0] o_out;
    logic         o_ERR;
    logic         o_lost;

    int unsigned n_checks;
    int unsigned n_pass;

    sm_shift_right_seq #(.N(N)) u_dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_start(i_start),
        .i_a    (i_a),
        .i_b    (i_b),
        .o_busy (o_busy),
        .o_done (o_done),
        .o_out  (o_out),
        .o_ERR  (o_ERR),
        .o_lost (o_lost)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Waits up to 40 edges for o_done; returns the number of edges after the accept edge.
    task automatic wait_done(input int unsigned start_lat, output int unsigned lat, output int unsigned busy_gaps);
        lat = start_lat;
        busy_gaps = 0;
        while (!o_done && lat < 40) begin
            if (!o_busy) busy_gaps++;
            @(posedge i_clk); #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int unsigned lat, input int unsigned busy_gaps,
                                input int unsigned exp_lat, input logic [N-1:0] exp_out,
                                input logic exp_err, input logic exp_lost);
        check_eq({tag, " latency"}, lat, exp_lat);
        check_eq({tag, " busy"}, {31'd0, o_busy}, 32'd1);
        check_eq({tag, " busy gaps"}, busy_gaps, 0);
        check_eq({tag, " out"}, {24'd0, o_out}, {24'd0, exp_out});
        check_eq({tag, " err"}, {31'd0, o_ERR}, {31'd0, exp_err});
        check_eq({tag, " lost"}, {31'd0, o_lost}, {31'd0, exp_lost});
        @(posedge i_clk); #1;
        check_eq({tag, " done pulse width"}, {31'd0, o_done}, 32'd0);
        check_eq({tag, " idle busy"}, {31'd0, o_busy}, 32'd0);
        check_eq({tag, " out held"}, {24'd0, o_out}, {24'd0, exp_out});
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input int unsigned exp_lat, input logic [N-1:0] exp_out,
                          input logic exp_err, input logic exp_lost);
        int unsigned lat;
        int unsigned gaps;
        i_a = a;
        i_b = b;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        wait_done(0, lat, gaps);
        check_result(tag, lat, gaps, exp_lat, exp_out, exp_err, exp_lost);
    endtask

    initial begin
        int unsigned lat;
        int unsigned gaps;
        int unsigned pulses;
        logic [N-1:0] exp_t1;
        logic [N-1:0] exp_t4b;

        n_checks = 0;
        n_pass   = 0;
        i_rst    = 1'b1;
        i_start  = 1'b0;
        i_a      = '0;
        i_b      = '0;
`ifdef SM_SHIFT_ROUND_EN
        exp_t1  = 8'h03;
        exp_t4b = 8'h81;
`else
        exp_t1  = 8'h02;
        exp_t4b = 8'h80;
`endif
        repeat (2) @(posedge i_clk);
        #1;
        check_eq("reset busy", {31'd0, o_busy}, 32'd0);
        check_eq("reset done", {31'd0, o_done}, 32'd0);
        check_eq("reset out", {24'd0, o_out}, 32'd0);
        check_eq("reset err", {31'd0, o_ERR}, 32'd0);
        check_eq("reset lost", {31'd0, o_lost}, 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        run_op("t1 +22>>3",   8'h16, 8'h03, 3, exp_t1, 1'b0, 1'b1);
        run_op("t2 -22>>1",   8'h96, 8'h01, 1, 8'h8B,  1'b0, 1'b0);
        run_op("t3 neg amt",  8'h45, 8'h81, 0, 8'h00,  1'b1, 1'b0);
        run_op("t3 zero amt", 8'h45, 8'h00, 0, 8'h45,  1'b0, 1'b0);
        run_op("t4 clamp",    8'hC5, 8'h0A, 0, 8'h80,  1'b0, 1'b1);
        run_op("t4 shift7",   8'hC5, 8'h07, 7, exp_t4b, 1'b0, 1'b1);
        run_op("neg zero amt", 8'h12, 8'h80, 0, 8'h00, 1'b1, 1'b0);
        run_op("minus zero",  8'h80, 8'h03, 3, 8'h80,  1'b0, 1'b0);
        run_op("clamp zero",  8'h80, 8'h08, 0, 8'h80,  1'b0, 1'b0);

        // A start during a shift is ignored; the original operands finish.
        i_a = 8'h2D; i_b = 8'h05; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(posedge i_clk); #1;
        i_a = 8'h7F; i_b = 8'h00; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        wait_done(2, lat, gaps);
        check_result("t5 busy start", lat, gaps, 5, 8'h01, 1'b0, 1'b1);
        run_op("t5 after", 8'h7F, 8'h00, 0, 8'h7F, 1'b0, 1'b0);

        // A reset during an operation aborts it without a done pulse.
        i_a = 8'h55; i_b = 8'h06; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        check_eq("t6 rst busy", {31'd0, o_busy}, 32'd0);
        check_eq("t6 rst done", {31'd0, o_done}, 32'd0);
        check_eq("t6 rst out", {24'd0, o_out}, 32'd0);
        check_eq("t6 rst err", {31'd0, o_ERR}, 32'd0);
        check_eq("t6 rst lost", {31'd0, o_lost}, 32'd0);
        i_rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge i_clk); #1;
            if (o_done || o_busy) pulses++;
        end
        check_eq("t6 no done after abort", pulses, 0);
        run_op("t6 fresh", 8'h55, 8'h06, 6, 8'h01, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sm_shift_right_seq.md
Name: sm_shift_right_seq

Overview:
- Multi-cycle right shifter for N-bit sign-magnitude operands, in the arithmetic-unit family.
- Divides i_a by 2^|i_b|, one bit position per clock, with a start/done handshake.
- Raises o_ERR for a negative shift amount and o_lost when nonzero magnitude bits are shifted out.
- Complements the combinational left shifter: left shift reports overflow; this block reports precision loss.

Parameters:
N, 8, operand/result width; MSB = sign, bits [N-2:0] = magnitude.

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, synchronous, active-high
i_start  input  1  request; sampled only in IDLE
i_a  input  N  sign-magnitude operand
i_b  input  N  sign-magnitude shift amount
o_busy  output  1  high whenever state != IDLE
o_done  output  1  one-cycle pulse; result valid
o_out  output  N  sign-magnitude result; holds until next accepted start
o_ERR  output  1  negative shift amount; valid with o_done, held
o_lost  output  1  some 1-bit shifted out of magnitude; valid with o_done, held

Behaviour:
- Clock and reset: one clock (i_clk). Reset is synchronous and active-high (i_rst).
- Reset values: state IDLE; o_busy=0, o_done=0, o_out=0, o_ERR=0, o_lost=0; internal regs 0.
- Reset mid-operation: abort at the next edge, return to IDLE, clear all outputs. No done pulse for the aborted op.
- All outputs are registered.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Stays in IDLE while i_start=0.
  - On i_start=1, latch sign_a=i_a[N-1], mag=i_a[N-2:0], cnt=i_b[N-2:0]. Clear ERR, lost and guard.
- Accept cases:
  - i_b[N-1]=1 (negative amount, including -0): next state DONE; result o_out=0, o_ERR=1, o_lost=0.
  - cnt=0: next state DONE; o_out=i_a, o_lost=0.
  - cnt>N-1: next state DONE; magnitude=0, sign kept, o_lost=(mag!=0).
  - 1<=cnt<=N-1: next state SHIFT.
- SHIFT (one cycle per shift):
  - guard<=mag[0]; lost<=lost|mag[0]; mag<=mag>>1; cnt<=cnt-1.
  - Go to DONE after the cycle with cnt==1. No early exit.
- DONE:
  - o_done=1 for exactly one cycle; o_out={sign_a, mag}.
  - Next state is always IDLE.
  - o_out, o_ERR and o_lost hold until the next accepted start.
- Latency, start at edge t:
  - done is high in cycle t+k+1 for a valid shift k in 1..N-1.
  - done is high in cycle t+1 for shift 0, clamped shifts and ERR.
- i_start while busy: ignored; no queuing.
- Sign is always preserved. A zero magnitude with sign 1 (-0) is a legal output; no normalization.
- The magnitude never grows, so no overflow flag is needed.

Optional Feature:
- Macro: SM_SHIFT_ROUND_EN.
- Defined:
  - On the SHIFT->DONE transition, if guard=1, then mag<=mag+1 (round half away from zero in magnitude).
  - The carry cannot overflow, because at least one shift occurred.
  - Clamped, ERR and cnt=0 paths never round.
  - o_lost still reports the truncated bits.
- Undefined: truncation only; guard is unused and may be optimized away.

Test Plan:
1. i_a=8'h16 (+22), i_b=8'h03, pulse start at t -> o_busy=1 during t+1..t+4; o_done at t+4; o_out=8'h02, o_lost=1, o_ERR=0. With SM_SHIFT_ROUND_EN: o_out=8'h03.
2. i_a=8'h96 (-22), i_b=8'h01 -> o_done at t+2; o_out=8'h8B, o_lost=0.
3. i_a=8'h45, i_b=8'h81 (negative) -> o_done at t+1; o_ERR=1, o_out=8'h00, o_lost=0. Also i_b=8'h00 -> o_out=8'h45 at t+1.
4. i_a=8'hC5, i_b=8'h0A (10>7) -> o_done at t+1; o_out=8'h80, o_lost=1. Also i_b=8'h07 -> o_done at t+8, o_out=8'h80; with SM_SHIFT_ROUND_EN o_out=8'h81 (mag 69>=64).
5. Start with i_b=8'h05; reassert i_start with other operands at t+2 -> ignored; original result at t+6; then a new start is accepted.
6. Start with i_b=8'h06; assert i_rst at t+3 -> next cycle IDLE with all outputs 0; no o_done pulse; a fresh start then completes normally.
